// File: rtl/cs_pkg.sv
// Shared constants, state encoding and select bundle for the bus_cs chip-select controller.
package cs_pkg;

  localparam logic [3:0] REG_ROM     = 4'h4;
  localparam logic [3:0] REG_SCSI    = 4'h5;
  localparam logic [3:0] REG_OVLRAM0 = 4'h6;
  localparam logic [3:0] REG_OVLRAM1 = 4'h7;
  localparam logic [3:0] REG_SCCR    = 4'h9;
  localparam logic [3:0] REG_SCCW    = 4'hB;
  localparam logic [3:0] REG_IWM     = 4'hD;
  localparam logic [3:0] REG_VIA     = 4'hE;
  localparam logic [3:0] REG_IACK    = 4'hF;

  localparam logic [3:0] VID_PAGE    = 4'hF;

  localparam logic [7:0] SND_FD = 8'hFD;
  localparam logic [7:0] SND_FE = 8'hFE;
  localparam logic [7:0] SND_FF = 8'hFF;
  localparam logic [7:0] SND_A1 = 8'hA1;
  localparam logic [7:0] SND_A2 = 8'hA2;
  localparam logic [7:0] SND_A3 = 8'hA3;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT
  } cs_state_e;

  typedef struct packed {
    logic fcs;
    logic iocs;
    logic iacs;
    logic romcs;
    logic ramcs;
    logic vidcs;
    logic sndcs;
  } cs_sel_t;

  // Sound buffer pages sit at the top and in the A1..A3 slice of the video page.
  function automatic logic isSndByte(input logic [7:0] b);
    return (b == SND_FD) || (b == SND_FE) || (b == SND_FF) ||
           (b == SND_A1) || (b == SND_A2) || (b == SND_A3);
  endfunction

endpackage

// File: rtl/cs_region_decode.sv
// Combinational A[23:8] region decode into the FSB/IOB select bundle.
// Optional macro CS_VIDWR_IO_EN mirrors video-RAM writes onto the IOB select.
module cs_region_decode
  import cs_pkg::*;
#(
  parameter int RAM_BANKS = 4
) (
  input  logic [15:0] addr_i,
  input  logic        nWe_i,
  input  logic        overlay_i,
  output cs_sel_t     sel_o
);

  localparam logic [4:0] BANK_LIMIT = 5'(RAM_BANKS);
  localparam logic [3:0] VID_BANK   = 4'(RAM_BANKS - 1);

  logic [3:0] region;
  logic [3:0] vidBank;
  logic       ramHit;
  logic       vidHit;

  assign region = addr_i[15:12];

  // With the overlay on, RAM is reachable only through the 6/7 alias while ROM covers region 0.
  always_comb begin
    ramHit  = 1'b0;
    vidBank = VID_BANK;
    if (overlay_i) begin
      ramHit  = (region == REG_OVLRAM0) || (region == REG_OVLRAM1);
      vidBank = REG_OVLRAM1;
    end else begin
      ramHit  = ({1'b0, region} < BANK_LIMIT);
    end
  end

  assign vidHit = ramHit && (region == vidBank) && (addr_i[11:8] == VID_PAGE);

  always_comb begin
    sel_o       = '0;
    sel_o.ramcs = ramHit;
    sel_o.vidcs = vidHit;
    sel_o.sndcs = vidHit && isSndByte(addr_i[7:0]);
    sel_o.romcs = (region == REG_ROM) || ((region == 4'h0) && overlay_i);
    sel_o.iacs  = (region == REG_IACK);
    unique case (region)
      REG_SCSI, REG_SCCR, REG_SCCW, REG_IWM, REG_VIA, REG_IACK: sel_o.iocs = 1'b1;
      default:                                                  sel_o.fcs  = 1'b1;
    endcase
`ifdef CS_VIDWR_IO_EN
    if (vidHit && !nWe_i) begin
      sel_o.iocs = 1'b1;
    end
`endif
  end

`ifndef CS_VIDWR_IO_EN
  logic unused_nwe;
  assign unused_nwe = nWe_i;
`endif

endmodule

// File: rtl/bus_cs.sv
// Registered 68030-side chip-select controller with boot overlay and ROM wait-state timer.
// Build option CS_VIDWR_IO_EN (see cs_region_decode) mirrors video writes onto IOCS.
module bus_cs
  import cs_pkg::*;
#(
  parameter int RAM_BANKS = 4,
  parameter int ROM_WS    = 2
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic [15:0] A,
  input  logic        nAS,
  input  logic        nWE,
  output logic        FCS,
  output logic        IOCS,
  output logic        IACS,
  output logic        ROMCS,
  output logic        RAMCS,
  output logic        VidRAMCS,
  output logic        SndRAMCS,
  output logic        ROMRdy,
  output logic        Overlay
);

  localparam logic [3:0] WS_LOAD = 4'(ROM_WS - 1);

  cs_state_e  state_q, state_d;
  cs_sel_t    sel_q, sel_d;
  cs_sel_t    selDec;
  logic [3:0] cnt_q, cnt_d;
  logic       romRdy_q, romRdy_d;
  logic       overlay_q, overlay_d;

  cs_region_decode #(
    .RAM_BANKS (RAM_BANKS)
  ) u_decode (
    .addr_i    (A),
    .nWe_i     (nWE),
    .overlay_i (overlay_q),
    .sel_o     (selDec)
  );

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      romRdy_q  <= 1'b0;
      overlay_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      romRdy_q  <= romRdy_d;
      overlay_q <= overlay_d;
    end
  end

  // Selects are captured only on the IDLE->ACTIVE edge, so later address changes are ignored.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    romRdy_d  = romRdy_q;
    overlay_d = overlay_q;
    if (nAS) begin
      state_d  = IDLE;
      sel_d    = '0;
      cnt_d    = '0;
      romRdy_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACTIVE;
          sel_d   = selDec;
          if (A[15:12] == REG_ROM) begin
            overlay_d = 1'b0;
          end
          if (selDec.romcs && (ROM_WS == 0)) begin
            romRdy_d = 1'b1;
          end
        end
        ACTIVE: begin
          if (sel_q.romcs && !romRdy_q) begin
            if (ROM_WS == 1) begin
              romRdy_d = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = WS_LOAD;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            romRdy_d = 1'b1;
            state_d  = ACTIVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign FCS      = sel_q.fcs;
  assign IOCS     = sel_q.iocs;
  assign IACS     = sel_q.iacs;
  assign ROMCS    = sel_q.romcs;
  assign RAMCS    = sel_q.ramcs;
  assign VidRAMCS = sel_q.vidcs;
  assign SndRAMCS = sel_q.sndcs;
  assign ROMRdy   = romRdy_q;
  assign Overlay  = overlay_q;

endmodule
